// File: rtl/ad_dly_tap_cal.sv
`timescale 1ns/1ps
// IDELAYE2 tap controller for the ADC capture lanes: default reload on re_sync,
// per-lane manual writes, and an eye scan that centres each lane in its widest window.
module ad_dly_tap_cal #(
  parameter int NUM_LANES  = 8,
  parameter int TAP_W      = 5,
  parameter int DEF_TAP    = 10,
  parameter int SETTLE_CYC = 16,
  parameter int SAMPLE_CYC = 64,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                           dly_clk,
  input  logic                           rst_n,
  input  logic                           dly_rdy,
  input  logic                           re_sync_in,
  input  logic                           cal_start,
  input  logic                           man_wr,
  input  logic [LANE_W-1:0]              man_lane,
  input  logic [TAP_W-1:0]               man_tap,
  input  logic [NUM_LANES-1:0]           lane_ok,
  output logic [NUM_LANES*TAP_W-1:0]     tap_load,
  output logic [NUM_LANES-1:0]           ld,
  output logic                           busy,
  output logic                           cal_done,
  output logic [NUM_LANES-1:0]           cal_fail,
  output logic [NUM_LANES*(TAP_W+1)-1:0] win_len
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] EVAL   = 3'd4;
  localparam logic [2:0] CENTER = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = 1;
  localparam logic [TAP_W-1:0] DEF_TAP_V   = TAP_W'(DEF_TAP);
  localparam logic [TAP_W-1:0] TAP_ONE     = 1;
  localparam logic [TAP_W-1:0] TAP_MAX     = '1;
  localparam logic [TAP_W:0]   LEN_ONE     = 1;

  logic [2:0]           state;
  logic                 sync_d1, sync_d2;
  logic                 resync_edge;
  logic                 scanning;
  logic                 man_ok;
  logic [TAP_W-1:0]     t;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_LANES-1:0] pass;
  logic [TAP_W:0]       run_len    [NUM_LANES];
  logic [TAP_W-1:0]     run_start  [NUM_LANES];
  logic [TAP_W:0]       best_len   [NUM_LANES];
  logic [TAP_W-1:0]     best_start [NUM_LANES];
  logic [TAP_W:0]       run_len_nx   [NUM_LANES];
  logic [TAP_W-1:0]     run_start_nx [NUM_LANES];

  // Floor centre of a window; the sum never exceeds the top tap, so the carry bit is dropped.
  function automatic logic [TAP_W-1:0] center_tap(input logic [TAP_W-1:0] start,
                                                  input logic [TAP_W:0]   len);
    logic [TAP_W:0] half;
    logic [TAP_W:0] sum;
    half = (len - LEN_ONE) >> 1;
    sum  = {1'b0, start} + half;
    return sum[TAP_W-1:0];
  endfunction

  assign resync_edge = sync_d1 & ~sync_d2;
  assign scanning    = (state != IDLE) && (state != DONE);
  assign man_ok      = man_wr && (int'(man_lane) < NUM_LANES);

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      run_len_nx[i]   = pass[i] ? (run_len[i] + LEN_ONE) : '0;
      run_start_nx[i] = (pass[i] && (run_len[i] == '0)) ? t : run_start[i];
    end
  end

  always_ff @(posedge dly_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d1  <= 1'b0;
      sync_d2  <= 1'b0;
      state    <= IDLE;
      t        <= '0;
      cnt      <= '0;
      pass     <= '0;
      tap_load <= {NUM_LANES{DEF_TAP_V}};
      ld       <= '0;
      busy     <= 1'b0;
      cal_done <= 1'b0;
      cal_fail <= '0;
      win_len  <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        run_len[i]    <= '0;
        run_start[i]  <= '0;
        best_len[i]   <= '0;
        best_start[i] <= '0;
      end
    end else begin
      sync_d1 <= re_sync_in;
      sync_d2 <= sync_d1;
      ld      <= '0;
      if (resync_edge && dly_rdy) begin
        tap_load <= {NUM_LANES{DEF_TAP_V}};
        ld       <= '1;
        busy     <= 1'b0;
        cal_done <= 1'b0;
        state    <= IDLE;
      end else if (scanning && !dly_rdy) begin
        // Lost reference mid-scan: taps stay where the sweep left them.
        busy     <= 1'b0;
        cal_done <= 1'b0;
        cal_fail <= '1;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (dly_rdy && cal_start) begin
              state    <= LOAD;
              busy     <= 1'b1;
              cal_done <= 1'b0;
              cal_fail <= '0;
              win_len  <= '0;
              t        <= '0;
              for (int i = 0; i < NUM_LANES; i++) begin
                run_len[i]    <= '0;
                run_start[i]  <= '0;
                best_len[i]   <= '0;
                best_start[i] <= '0;
              end
            end else if (dly_rdy && man_ok) begin
              tap_load[man_lane*TAP_W +: TAP_W] <= man_tap;
              ld[man_lane]                      <= 1'b1;
            end
          end
          LOAD: begin
            tap_load <= {NUM_LANES{t}};
            ld       <= '1;
            cnt      <= '0;
            state    <= SETTLE;
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              pass  <= '1;
              state <= SAMPLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          SAMPLE: begin
            pass <= pass & lane_ok;
            if (cnt == SAMPLE_LAST) begin
              cnt   <= '0;
              state <= EVAL;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          EVAL: begin
            // Strict compare keeps the lowest-start window on ties.
            for (int i = 0; i < NUM_LANES; i++) begin
              run_len[i]   <= run_len_nx[i];
              run_start[i] <= run_start_nx[i];
              if (run_len_nx[i] > best_len[i]) begin
                best_len[i]   <= run_len_nx[i];
                best_start[i] <= run_start_nx[i];
              end
            end
            if (t == TAP_MAX) begin
              state <= CENTER;
            end else begin
              t     <= t + TAP_ONE;
              state <= LOAD;
            end
          end
          CENTER: begin
            for (int i = 0; i < NUM_LANES; i++) begin
              tap_load[i*TAP_W +: TAP_W] <= (best_len[i] == '0) ? DEF_TAP_V
                                            : center_tap(best_start[i], best_len[i]);
              cal_fail[i]                    <= (best_len[i] == '0);
              win_len[i*(TAP_W+1) +: TAP_W+1] <= best_len[i];
            end
            ld    <= '1;
            busy  <= 1'b0;
            state <= DONE;
          end
          DONE: begin
            cal_done <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad_dly_tap_cal.sv
`timescale 1ns/1ps
// Directed bench for ad_dly_tap_cal: reset, manual writes, re_sync reload,
// eye scans against a per-lane pattern model, and both abort paths.
module tb_ad_dly_tap_cal;

  localparam logic [39:0] DEF_ALL  = {8{5'd10}};
  localparam logic [39:0] TAP1_ALL = {8{5'd1}};
  localparam logic [24:0] DEF5_ALL = {5{5'd10}};
  localparam int          SCAN_LEN = 32 * (16 + 64 + 2) + 2;

  logic        dly_clk = 1'b0;
  logic        rst_n, dly_rdy, re_sync_in, cal_start, man_wr;
  logic [2:0]  man_lane;
  logic [4:0]  man_tap;
  logic [7:0]  lane_ok = '1;
  logic [39:0] tap_load;
  logic [7:0]  ld;
  logic        busy, cal_done;
  logic [7:0]  cal_fail;
  logic [47:0] win_len;

  logic        man_wr5;
  logic [2:0]  man_lane5;
  logic [4:0]  man_tap5;
  logic [24:0] tap_load5;
  logic [4:0]  ld5, cal_fail5;
  logic        busy5, cal_done5;
  logic [29:0] win_len5;

  int n_chk = 0;
  int n_fail = 0;
  bit scan_mode = 1'b0;
  int since_ld = 0;

  typedef struct { int lane; int tap; logic [7:0] exp_ld; } man_vec_t;
  typedef struct { logic [4:0] exp_tap; logic [5:0] exp_win; logic exp_fail; } scan_vec_t;
  man_vec_t  mv [4];
  scan_vec_t sv [8];

  always #2.5 dly_clk = ~dly_clk;

  ad_dly_tap_cal u_dut (
    .dly_clk(dly_clk), .rst_n(rst_n), .dly_rdy(dly_rdy), .re_sync_in(re_sync_in),
    .cal_start(cal_start), .man_wr(man_wr), .man_lane(man_lane), .man_tap(man_tap),
    .lane_ok(lane_ok), .tap_load(tap_load), .ld(ld), .busy(busy), .cal_done(cal_done),
    .cal_fail(cal_fail), .win_len(win_len)
  );

  ad_dly_tap_cal #(.NUM_LANES(5)) u_dut5 (
    .dly_clk(dly_clk), .rst_n(rst_n), .dly_rdy(dly_rdy), .re_sync_in(1'b0),
    .cal_start(1'b0), .man_wr(man_wr5), .man_lane(man_lane5), .man_tap(man_tap5),
    .lane_ok(5'b0), .tap_load(tap_load5), .ld(ld5), .busy(busy5), .cal_done(cal_done5),
    .cal_fail(cal_fail5), .win_len(win_len5)
  );

  // Eye model: which taps each lane's pattern checker passes at.
  function automatic bit ok_at(int lane, int tap);
    case (lane)
      0: return (tap >= 8) && (tap <= 20);
      1: return (tap <= 3) || (tap >= 20);
      2: return ((tap >= 2) && (tap <= 5)) || ((tap >= 10) && (tap <= 13));
      3: return 1'b0;
      6: return tap == 31;
      7: return (tap == 0) || (tap == 31);
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge dly_clk) begin
    if (ld != 0) since_ld = 0;
    else if (since_ld < 100000) since_ld = since_ld + 1;
    for (int i = 0; i < 8; i++)
      lane_ok[i] = scan_mode ? ok_at(i, int'(tap_load[i*5 +: 5])) : 1'b1;
    if (scan_mode && tap_load[20 +: 5] == 5'd15 && since_ld == 40) lane_ok[4] = 1'b0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] lane_tap(int i);
    return tap_load[i*5 +: 5];
  endfunction

  task automatic run_scan(output int done_n, output int busy_n, output int ld_n,
                          output logic [39:0] first_tap);
    cal_start = 1'b1;
    @(negedge dly_clk);
    cal_start = 1'b0;
    done_n = -1; busy_n = 0; ld_n = 0; first_tap = '1;
    for (int n = 0; n < 4000; n++) begin
      if (n > 0) @(negedge dly_clk);
      if (cal_done) begin
        done_n = n;
        break;
      end
      if (busy) busy_n++;
      if (ld != 0) begin
        if (ld_n == 0) first_tap = tap_load;
        ld_n++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_n, busy_n, ld_n, pulses;
    bit found;
    logic [39:0] first_tap;

    mv[0] = '{3, 22, 8'h08};
    mv[1] = '{0, 31, 8'h01};
    mv[2] = '{7, 0,  8'h80};
    mv[3] = '{5, 5,  8'h20};
    sv[0] = '{5'd14, 6'd13, 1'b0};
    sv[1] = '{5'd25, 6'd12, 1'b0};
    sv[2] = '{5'd3,  6'd4,  1'b0};
    sv[3] = '{5'd10, 6'd0,  1'b1};
    sv[4] = '{5'd23, 6'd16, 1'b0};
    sv[5] = '{5'd15, 6'd32, 1'b0};
    sv[6] = '{5'd31, 6'd1,  1'b0};
    sv[7] = '{5'd0,  6'd1,  1'b0};

    rst_n = 1'b0; dly_rdy = 1'b1; re_sync_in = 1'b0; cal_start = 1'b0;
    man_wr = 1'b0; man_lane = '0; man_tap = '0;
    man_wr5 = 1'b0; man_lane5 = '0; man_tap5 = '0;
    repeat (3) @(negedge dly_clk);
    check("rst_tap_load", tap_load, DEF_ALL);
    check("rst_ld", ld, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge dly_clk);
    check("rel_tap_load", tap_load, DEF_ALL);
    check("rel_ld", ld, 0);
    check("rel_busy", busy, 0);
    check("rel_cal_done", cal_done, 0);
    check("rel_cal_fail", cal_fail, 0);
    check("rel_win_len", win_len, 0);

    for (int i = 0; i < 4; i++) begin
      man_wr = 1'b1; man_lane = 3'(mv[i].lane); man_tap = 5'(mv[i].tap);
      @(negedge dly_clk);
      man_wr = 1'b0;
      check($sformatf("man_ld_%0d", i), ld, mv[i].exp_ld);
      check($sformatf("man_tap_%0d", i), lane_tap(mv[i].lane), mv[i].tap);
      @(negedge dly_clk);
      check($sformatf("man_ld_end_%0d", i), ld, 0);
    end

    man_wr5 = 1'b1; man_lane5 = 3'd6; man_tap5 = 5'd3;
    @(negedge dly_clk);
    man_wr5 = 1'b0;
    check("man_oob_ld", ld5, 0);
    check("man_oob_tap", tap_load5, DEF5_ALL);
    man_wr5 = 1'b1; man_lane5 = 3'd4; man_tap5 = 5'd7;
    @(negedge dly_clk);
    man_wr5 = 1'b0;
    check("man5_ld", ld5, 5'h10);
    check("man5_tap", tap_load5[20 +: 5], 5'd7);

    re_sync_in = 1'b1;
    @(negedge dly_clk);
    check("resync_early_ld", ld, 0);
    @(negedge dly_clk);
    check("resync_ld", ld, 8'hFF);
    check("resync_tap", tap_load, DEF_ALL);
    pulses = 0;
    repeat (6) begin
      @(negedge dly_clk);
      if (ld != 0) pulses++;
    end
    check("resync_hold_pulses", pulses, 0);
    re_sync_in = 1'b0;
    repeat (3) @(negedge dly_clk);

    scan_mode = 1'b1;
    run_scan(done_n, busy_n, ld_n, first_tap);
    check("scan_done_latency", done_n, SCAN_LEN);
    check("scan_busy_cycles", busy_n, SCAN_LEN - 1);
    check("scan_ld_pulses", ld_n, 33);
    check("scan_first_tap", first_tap, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("scan_tap_l%0d", i), lane_tap(i), sv[i].exp_tap);
      check($sformatf("scan_win_l%0d", i), win_len[i*6 +: 6], sv[i].exp_win);
      check($sformatf("scan_fail_l%0d", i), cal_fail[i], sv[i].exp_fail);
    end
    check("scan_busy_after", busy, 0);

    cal_start = 1'b1;
    @(negedge dly_clk);
    cal_start = 1'b0;
    check("rescan_done_cleared", cal_done, 0);
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge dly_clk);
      if (ld != 0 && lane_tap(0) == 5'd12) found = 1'b1;
    end
    check("midscan_reach_tap12", found, 1);
    repeat (20) @(negedge dly_clk);
    re_sync_in = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 4 && !found; n++) begin
      @(negedge dly_clk);
      if (ld != 0) found = 1'b1;
    end
    check("midscan_resync_seen", found, 1);
    check("midscan_resync_ld", ld, 8'hFF);
    check("midscan_resync_tap", tap_load, DEF_ALL);
    check("midscan_resync_busy", busy, 0);
    check("midscan_resync_done", cal_done, 0);
    check("midscan_resync_fail", cal_fail, 0);
    check("midscan_resync_win", win_len, 0);
    re_sync_in = 1'b0;
    repeat (3) @(negedge dly_clk);

    run_scan(done_n, busy_n, ld_n, first_tap);
    check("rerun_done_latency", done_n, SCAN_LEN);
    check("rerun_first_tap", first_tap, 0);
    check("rerun_tap_l0", lane_tap(0), 5'd14);
    check("rerun_cal_fail", cal_fail, 8'h08);

    cal_start = 1'b1;
    @(negedge dly_clk);
    cal_start = 1'b0;
    repeat (100) @(negedge dly_clk);
    dly_rdy = 1'b0;
    @(negedge dly_clk);
    check("rdy_drop_busy", busy, 0);
    check("rdy_drop_fail", cal_fail, 8'hFF);
    check("rdy_drop_done", cal_done, 0);
    check("rdy_drop_ld", ld, 0);
    check("rdy_drop_tap", tap_load, TAP1_ALL);
    cal_start = 1'b1;
    @(negedge dly_clk);
    cal_start = 1'b0;
    re_sync_in = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge dly_clk);
      if (ld != 0 || busy) pulses++;
    end
    check("rdy_low_ignored", pulses, 0);
    check("rdy_low_fail_kept", cal_fail, 8'hFF);
    check("rdy_low_tap_kept", tap_load, TAP1_ALL);
    dly_rdy = 1'b1;
    re_sync_in = 1'b0;
    repeat (3) @(negedge dly_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
